// File: rtl/piece_drop_ctrl.sv
// piece_drop_ctrl
// Lifecycle sequencer for the falling piece: spawn, gravity-timed descent,
// lock delay, lock, line-clear handoff and game over. Every output is
// registered; strobes are single-cycle and mutually exclusive.
module piece_drop_ctrl #(
    parameter int unsigned GRAVITY_DIV = 50_000_000,
    parameter int unsigned FAST_DIV    = 5_000_000,
    parameter int unsigned LOCK_TICKS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        soft_drop,
    input  logic [2:0]  piece_in,
    input  logic        spawn_blocked,
    input  logic        blocked_below,
    input  logic        clear_done,
    output logic [2:0]  state,
    output logic [2:0]  piece_type,
    output logic [4:0]  drop_row,
    output logic        spawn,
    output logic        step_down,
    output logic        lock,
    output logic        clear_start,
    output logic        game_over,
    output logic [15:0] pieces_placed
);

    // Prescaler only ever holds values up to GRAVITY_DIV-1.
    localparam int unsigned PW = (GRAVITY_DIV > 2) ? $clog2(GRAVITY_DIV) : 1;
    localparam int unsigned LW = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS + 1) : 1;

    localparam logic [PW-1:0] GRAV_LAST = PW'(GRAVITY_DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TICKS - 1);
    localparam logic [4:0]    ROW_MAX   = 5'd21;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPAWN   = 3'd1,
        S_FALL    = 3'd2,
        S_LOCKDLY = 3'd3,
        S_LOCK    = 3'd4,
        S_CLRREQ  = 3'd5,
        S_CLRWAIT = 3'd6,
        S_OVER    = 3'd7
    } state_t;

    state_t         cur_state;
    state_t         nxt_state;
    logic [PW-1:0]  prescaler;
    logic [PW-1:0]  nxt_prescaler;
    logic [LW-1:0]  lock_cnt;
    logic [LW-1:0]  nxt_lock_cnt;
    logic [2:0]     nxt_piece_type;
    logic [4:0]     nxt_drop_row;
    logic [15:0]    nxt_pieces_placed;
    logic           nxt_spawn;
    logic           nxt_step_down;
    logic           nxt_lock;
    logic           nxt_clear_start;
    logic           nxt_game_over;

    logic [PW-1:0]  limit_last;
    logic           tick;
    logic [PW-1:0]  prescaler_run;

    assign state = cur_state;

    // Gravity timing: limit is re-evaluated every cycle, and using >= means a
    // rate switch with the prescaler already past the new limit ticks at once.
    always_comb begin
        limit_last    = soft_drop ? FAST_LAST : GRAV_LAST;
        tick          = (prescaler >= limit_last);
        prescaler_run = tick ? '0 : prescaler + 1'b1;
    end

    // Next-state and next-output logic; strobes default low each cycle.
    always_comb begin
        nxt_state         = cur_state;
        nxt_prescaler     = prescaler;
        nxt_lock_cnt      = lock_cnt;
        nxt_piece_type    = piece_type;
        nxt_drop_row      = drop_row;
        nxt_pieces_placed = pieces_placed;
        nxt_spawn         = 1'b0;
        nxt_step_down     = 1'b0;
        nxt_lock          = 1'b0;
        nxt_clear_start   = 1'b0;

        case (cur_state)
            S_IDLE: begin
                if (start) begin
                    nxt_state         = S_SPAWN;
                    nxt_pieces_placed = '0;
                end
            end

            S_SPAWN: begin
                nxt_piece_type = piece_in;
                nxt_drop_row   = '0;
                nxt_prescaler  = '0;
                if (spawn_blocked) begin
                    nxt_state = S_OVER;
                end else begin
                    nxt_state = S_FALL;
                    nxt_spawn = 1'b1;
                end
            end

            S_FALL: begin
                nxt_prescaler = prescaler_run;
                if (tick) begin
                    if (blocked_below) begin
                        nxt_state    = S_LOCKDLY;
                        nxt_lock_cnt = '0;
                    end else if (drop_row < ROW_MAX) begin
                        nxt_drop_row  = drop_row + 5'd1;
                        nxt_step_down = 1'b1;
                    end
                end
            end

            S_LOCKDLY: begin
                nxt_prescaler = prescaler_run;
                // Losing ground wins over a coincident tick; the timer keeps
                // running so the return to FALL does not restart the period.
                if (!blocked_below) begin
                    nxt_state = S_FALL;
                end else if (tick) begin
                    if (lock_cnt == LOCK_LAST) begin
                        nxt_state = S_LOCK;
                        nxt_lock  = 1'b1;
                        if (pieces_placed != 16'hFFFF) begin
                            nxt_pieces_placed = pieces_placed + 16'd1;
                        end
                    end else begin
                        nxt_lock_cnt = lock_cnt + 1'b1;
                    end
                end
            end

            S_LOCK: begin
                nxt_state       = S_CLRREQ;
                nxt_clear_start = 1'b1;
            end

            S_CLRREQ: begin
                nxt_state = S_CLRWAIT;
            end

            S_CLRWAIT: begin
                if (clear_done) begin
                    nxt_state = S_SPAWN;
                end
            end

            S_OVER: begin
                if (start) begin
                    nxt_state         = S_SPAWN;
                    nxt_pieces_placed = '0;
                end
            end

            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        nxt_game_over = (nxt_state == S_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= S_IDLE;
            prescaler     <= '0;
            lock_cnt      <= '0;
            piece_type    <= '0;
            drop_row      <= '0;
            pieces_placed <= '0;
            spawn         <= 1'b0;
            step_down     <= 1'b0;
            lock          <= 1'b0;
            clear_start   <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            prescaler     <= nxt_prescaler;
            lock_cnt      <= nxt_lock_cnt;
            piece_type    <= nxt_piece_type;
            drop_row      <= nxt_drop_row;
            pieces_placed <= nxt_pieces_placed;
            spawn         <= nxt_spawn;
            step_down     <= nxt_step_down;
            lock          <= nxt_lock;
            clear_start   <= nxt_clear_start;
            game_over     <= nxt_game_over;
        end
    end

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Scoreboarded bench for piece_drop_ctrl: a cycle-level reference model
// predicts the registered outputs after every edge; a monitor compares.
module tb_piece_drop_ctrl;

    localparam int G = 4;
    localparam int F = 2;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        soft_drop = 1'b0;
    logic [2:0]  piece_in = 3'd0;
    logic        spawn_blocked = 1'b0;
    logic        blocked_below = 1'b0;
    logic        clear_done = 1'b0;
    logic [2:0]  state;
    logic [2:0]  piece_type;
    logic [4:0]  drop_row;
    logic        spawn;
    logic        step_down;
    logic        lock;
    logic        clear_start;
    logic        game_over;
    logic [15:0] pieces_placed;

    piece_drop_ctrl #(
        .GRAVITY_DIV(G),
        .FAST_DIV   (F),
        .LOCK_TICKS (N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .soft_drop    (soft_drop),
        .piece_in     (piece_in),
        .spawn_blocked(spawn_blocked),
        .blocked_below(blocked_below),
        .clear_done   (clear_done),
        .state        (state),
        .piece_type   (piece_type),
        .drop_row     (drop_row),
        .spawn        (spawn),
        .step_down    (step_down),
        .lock         (lock),
        .clear_start  (clear_start),
        .game_over    (game_over),
        .pieces_placed(pieces_placed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [2:0]  pt;
        logic [4:0]  row;
        logic        sp;
        logic        sd;
        logic        lk;
        logic        cs;
        logic        go;
        logic [15:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: phase numbers follow the visible state codes.
    int m_phase = 0;
    int m_piece = 0;
    int m_row   = 0;
    int m_timer = 0;
    int m_ticks_on_ground = 0;
    int m_placed = 0;
    bit m_sp, m_sd, m_lk, m_cs;

    task automatic model_step(input bit r, input bit s, input bit sd,
                              input int pc, input bit sblk, input bit bb,
                              input bit cd);
        int  lim;
        bit  gticked;
        obs_t e;
        m_sp = 0; m_sd = 0; m_lk = 0; m_cs = 0;
        if (r) begin
            m_phase = 0; m_piece = 0; m_row = 0; m_timer = 0;
            m_ticks_on_ground = 0; m_placed = 0;
        end else begin
            lim = sd ? F : G;
            gticked = 0;
            if (m_phase == 2 || m_phase == 3) begin
                if (m_timer >= lim - 1) begin
                    gticked = 1;
                    m_timer = 0;
                end else begin
                    m_timer = m_timer + 1;
                end
            end
            case (m_phase)
                0, 7: if (s) begin m_phase = 1; m_placed = 0; end
                1: begin
                    m_piece = pc; m_row = 0; m_timer = 0;
                    if (sblk) m_phase = 7;
                    else begin m_phase = 2; m_sp = 1; end
                end
                2: if (gticked) begin
                    if (bb) begin m_phase = 3; m_ticks_on_ground = 0; end
                    else if (m_row < 21) begin m_row = m_row + 1; m_sd = 1; end
                end
                3: begin
                    if (!bb) m_phase = 2;
                    else if (gticked) begin
                        m_ticks_on_ground = m_ticks_on_ground + 1;
                        if (m_ticks_on_ground == N) begin
                            m_phase = 4; m_lk = 1;
                            if (m_placed < 65535) m_placed = m_placed + 1;
                        end
                    end
                end
                4: begin m_phase = 5; m_cs = 1; end
                5: m_phase = 6;
                6: if (cd) m_phase = 1;
                default: m_phase = 0;
            endcase
        end
        e.st  = 3'(m_phase);
        e.pt  = 3'(m_piece);
        e.row = 5'(m_row);
        e.sp  = m_sp;
        e.sd  = m_sd;
        e.lk  = m_lk;
        e.cs  = m_cs;
        e.go  = (m_phase == 7);
        e.cnt = 16'(m_placed);
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs and record the predicted post-edge outputs.
    task automatic apply(input bit r, input bit s, input bit sd, input int pc,
                         input bit sblk, input bit bb, input bit cd);
        @(negedge clk);
        rst = r; start = s; soft_drop = sd; piece_in = 3'(pc);
        spawn_blocked = sblk; blocked_below = bb; clear_done = cd;
        model_step(r, s, sd, pc, sblk, bb, cd);
    endtask

    task automatic hold(input int n, input bit r, input bit s, input bit sd,
                        input int pc, input bit sblk, input bit bb, input bit cd);
        for (int i = 0; i < n; i++) apply(r, s, sd, pc, sblk, bb, cd);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge.
    always @(posedge clk) begin
        obs_t exp_o;
        obs_t act_o;
        #1;
        if (sb.size() != 0) begin
            exp_o = sb.pop_front();
            act_o.st = state;       act_o.pt = piece_type; act_o.row = drop_row;
            act_o.sp = spawn;       act_o.sd = step_down;  act_o.lk = lock;
            act_o.cs = clear_start; act_o.go = game_over;  act_o.cnt = pieces_placed;
            checks++;
            if (act_o === exp_o) passes++;
            else $display("FAIL outputs t=%0t got st=%0d pt=%0d row=%0d sp%b sd%b lk%b cs%b go%b cnt=%0d want st=%0d pt=%0d row=%0d sp%b sd%b lk%b cs%b go%b cnt=%0d",
                          $time, act_o.st, act_o.pt, act_o.row, act_o.sp, act_o.sd, act_o.lk,
                          act_o.cs, act_o.go, act_o.cnt, exp_o.st, exp_o.pt, exp_o.row,
                          exp_o.sp, exp_o.sd, exp_o.lk, exp_o.cs, exp_o.go, exp_o.cnt);
            checks++;
            if ($countones({spawn, step_down, lock, clear_start}) <= 1) passes++;
            else $display("FAIL strobe_exclusive t=%0t got %b want at most one set",
                          $time, {spawn, step_down, lock, clear_start});
        end
    end

    initial begin
        bit soft_lvl;
        bit bb_lvl;
        // reset, start, free fall
        hold(2, 1, 0, 0, 3, 0, 0, 0);
        apply(0, 1, 0, 3, 0, 0, 0);
        hold(15, 0, 0, 0, 3, 0, 0, 0);
        // soft drop on and off mid-fall
        hold(7, 0, 0, 1, 3, 0, 0, 0);
        hold(10, 0, 0, 0, 3, 0, 0, 0);
        // ground the piece, let it lock and hand off to line clear
        hold(16, 0, 0, 0, 3, 0, 1, 0);
        hold(2, 0, 0, 0, 3, 0, 0, 0);
        apply(0, 0, 0, 5, 0, 0, 1);
        // leave the ground briefly during lock delay, then re-ground
        hold(6, 0, 0, 0, 5, 0, 0, 0);
        hold(5, 0, 0, 0, 5, 0, 1, 0);
        apply(0, 0, 0, 5, 0, 0, 0);
        hold(14, 0, 0, 0, 5, 0, 1, 0);
        // clear finishes, spawn is blocked -> game over, restart
        apply(0, 0, 0, 2, 1, 0, 1);
        hold(3, 0, 0, 0, 2, 1, 0, 0);
        apply(0, 1, 0, 6, 0, 0, 0);
        // run all the way to the floor row with soft drop
        hold(60, 0, 0, 1, 6, 0, 0, 0);
        // lock and sit in CLRWAIT, reset there, late clear_done
        hold(16, 0, 0, 0, 6, 0, 1, 0);
        apply(1, 0, 0, 6, 0, 1, 0);
        apply(0, 0, 0, 6, 0, 1, 1);
        hold(3, 0, 0, 0, 6, 0, 0, 0);
        // randomized phase
        soft_lvl = 0;
        bb_lvl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) soft_lvl = ~soft_lvl;
            if ($urandom_range(0, 6) == 0) bb_lvl = ~bb_lvl;
            apply($urandom_range(0, 399) == 0,
                  $urandom_range(0, 19) == 0,
                  soft_lvl,
                  int'($urandom_range(0, 6)),
                  $urandom_range(0, 11) == 0,
                  bb_lvl,
                  $urandom_range(0, 4) == 0);
        end
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
